gate_truth_table_checker: RTL and testbench

Sequential self-checker that sits directly around a 2-input combinational gate-under-test (e.g. a mux-built AND gate): it drives the gate's `a`/`b` inputs through all four input combinations and consumes the gate's output. Each sample is compared against the expected truth table selected by `op`. It reports pass/fail, a mismatch count and, optionally, the first failing vector. It is the on-chip counterpart of the combinational exercise benches and feeds the gate-level exercises in the combinational-logic level.

---
 rtl/gate_truth_table_checker.sv | 185 ++++++++++++++++++
 tb/tb_gate_truth_table_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_table_checker
//
// Drives a 2-input combinational gate-under-test through the four input
// vectors 00, 01, 10, 11 (a is the vector MSB). Each vector is held for
// SETTLE_CYCLES settle cycles plus one sample cycle. At the closing edge of
// the sample cycle the gate output is compared with the truth table that
// `op` selected when the run was started.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before its sample cycle (1..15)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   run request, accepted in IDLE or DONE
//   op          in   [1:0] expected function: 00 AND, 01 OR, 10 XOR, 11 NAND
//   dut_a       out  gate-under-test input a (registered)
//   dut_b       out  gate-under-test input b (registered)
//   dut_o       in   gate-under-test output
//   busy        out  run in progress
//   done        out  one-cycle pulse in the final (DONE) cycle of a run
//   pass        out  last run had zero mismatches
//   err_cnt     out  [2:0] mismatch count of the last run (0..4)
//   fail_valid  out  a mismatch was captured in the current/last run
//   fail_vec    out  [1:0] {a,b} of the first mismatching vector
//
// Build option:
//   GATE_CHECK_FAIL_CAPTURE_EN  when defined, fail_valid/fail_vec record the
//                               first failing vector; otherwise both are
//                               tied to 0 and the capture logic is omitted.
//
// FSM states:
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start, gate inputs parked at 00
//   DRIVE  | current vector applied, settle down-counter running
//   SAMPLE | vector still applied, dut_o compared at the closing edge
//   DONE   | one-cycle end of run, done pulse, results valid
// -----------------------------------------------------------------------------
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  // Settle timer reload: a down-counter that reaches terminal count (0) on
  // the last settle cycle of the vector.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] op_q;
  logic [1:0] vec;
  logic [3:0] settle_cnt;

  logic       start_accept;
  logic       sample_fire;
  logic       expected_o;
  logic       mismatch;
  logic [2:0] err_next;

  assign start_accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign sample_fire  = (state == ST_SAMPLE);

  always_comb begin
    expected_o = 1'b0;
    case (op_q)
      OP_AND:  expected_o =   vec[1] & vec[0];
      OP_OR:   expected_o =   vec[1] | vec[0];
      OP_XOR:  expected_o =   vec[1] ^ vec[0];
      default: expected_o = ~(vec[1] & vec[0]);
    endcase
  end

  assign mismatch = (dut_o != expected_o);
  assign err_next = err_cnt + {2'b00, mismatch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= 2'b00;
      vec        <= 2'b00;
      settle_cnt <= 4'd0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_accept) begin
            op_q          <= op;
            vec           <= 2'b00;
            settle_cnt    <= SETTLE_LOAD;
            err_cnt       <= 3'd0;
            pass          <= 1'b0;
            {dut_a, dut_b} <= 2'b00;
            busy          <= 1'b1;
            state         <= ST_DRIVE;
          end else begin
            {dut_a, dut_b} <= 2'b00;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        ST_DRIVE: begin
          if (settle_cnt == 4'd0) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        ST_SAMPLE: begin
          err_cnt <= err_next;
          if (vec == 2'b11) begin
            // Last vector: park the gate inputs and publish the verdict
            // together with the done pulse.
            {dut_a, dut_b} <= 2'b00;
            busy          <= 1'b0;
            done          <= 1'b1;
            pass          <= (err_next == 3'd0);
            state         <= ST_DONE;
          end else begin
            vec           <= vec + 2'd1;
            {dut_a, dut_b} <= vec + 2'd1;
            settle_cnt    <= SETTLE_LOAD;
            state         <= ST_DRIVE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GATE_CHECK_FAIL_CAPTURE_EN
  // Only the first mismatch of a run is recorded; later ones just count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_valid <= 1'b0;
      fail_vec   <= 2'b00;
    end else if (start_accept) begin
      fail_valid <= 1'b0;
      fail_vec   <= 2'b00;
    end else if (sample_fire && mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= vec;
    end
  end
`else
  assign fail_valid = 1'b0;
  assign fail_vec   = 2'b00;
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
module tb_gate_truth_table_checker;

  logic       clk;
  logic       rst;
  logic [1:0] op;
  logic [3:0] gate_tt;   // gate-under-test truth table, indexed by {a,b}
  int         cur_sel;   // 0: SETTLE_CYCLES=1 instance, 1: SETTLE_CYCLES=3

  logic start1, a1, b1, o1, busy1, done1, pass1, fv1;
  logic [2:0] err1;
  logic [1:0] fvec1;
  logic start3, a3, b3, o3, busy3, done3, pass3, fv3;
  logic [2:0] err3;
  logic [1:0] fvec3;

  int n_checks = 0;
  int n_fail   = 0;

  assign o1 = gate_tt[{a1, b1}];
  assign o3 = gate_tt[{a3, b3}];

  gate_truth_table_checker #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .op(op),
    .dut_a(a1), .dut_b(b1), .dut_o(o1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_valid(fv1), .fail_vec(fvec1)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start3), .op(op),
    .dut_a(a3), .dut_b(b3), .dut_o(o3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_valid(fv3), .fail_vec(fvec3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] m_ab;
  logic       m_busy, m_done, m_pass, m_fv;
  logic [2:0] m_err;
  logic [1:0] m_fvec;

  always_comb begin
    if (cur_sel == 0) begin
      m_ab = {a1, b1}; m_busy = busy1; m_done = done1; m_pass = pass1;
      m_err = err1; m_fv = fv1; m_fvec = fvec1;
    end else begin
      m_ab = {a3, b3}; m_busy = busy3; m_done = done3; m_pass = pass3;
      m_err = err3; m_fv = fv3; m_fvec = fvec3;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] truth(input logic [1:0] o);
    case (o)
      2'b00:   return 4'b1000;  // AND
      2'b01:   return 4'b1110;  // OR
      2'b10:   return 4'b0110;  // XOR
      default: return 4'b0111;  // NAND
    endcase
  endfunction

  function automatic int model_err(input logic [1:0] o, input logic [3:0] tt);
    logic [3:0] d;
    d = truth(o) ^ tt;
    return $countones(d);
  endfunction

  function automatic int model_fvec(input logic [1:0] o, input logic [3:0] tt);
    logic [3:0] d;
    d = truth(o) ^ tt;
    for (int v = 0; v < 4; v++) if (d[v]) return v;
    return 0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start1 = v; else start3 = v;
  endtask

  task automatic chk_results(input string nm, input int exp_err, input int exp_fvec);
    int efv, efvec;
`ifdef GATE_CHECK_FAIL_CAPTURE_EN
    efv   = (exp_err != 0) ? 1 : 0;
    efvec = (exp_err != 0) ? exp_fvec : 0;
`else
    efv   = 0;
    efvec = 0;
`endif
    chk({nm, " err_cnt"},    int'(m_err), exp_err);
    chk({nm, " pass"},       int'(m_pass), (exp_err == 0) ? 1 : 0);
    chk({nm, " fail_valid"}, int'(m_fv), efv);
    chk({nm, " fail_vec"},   int'(m_fvec), efvec);
  endtask

  // Call at a negedge; start is raised here so the next posedge is E0.
  // With chain=1 the task returns in the DONE cycle so the caller can issue
  // a back-to-back start.
  task automatic do_run(input int sel, input logic [1:0] op_i, input logic [3:0] tt_i,
                        input bit mid, input bit chain, input int exp_err,
                        input int exp_fvec, input string nm);
    int per, len, last, done_c, done_n;
    per    = (sel == 0) ? 2 : 4;
    len    = 4 * per + 1;
    last   = chain ? len : len + 2;
    done_c = 0;
    done_n = 0;
    cur_sel = sel;
    gate_tt = tt_i;
    op      = op_i;
    set_start(sel, 1'b1);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      // Extra start pulses (with a different op) land in DRIVE/SAMPLE
      // cycles and must not disturb the run.
      if (mid && (c == 1 || c == per || c == 2 * per + 1)) begin
        set_start(sel, 1'b1);
        op = ~op_i;
      end else begin
        set_start(sel, 1'b0);
        op = op_i;
      end
      if (m_done) begin
        done_n++;
        if (done_c == 0) done_c = c;
      end
      if (c < len) begin
        chk({nm, " vec"},  int'(m_ab), (c - 1) / per);
        chk({nm, " busy"}, int'(m_busy), 1);
      end else begin
        chk({nm, " idle_vec"},  int'(m_ab), 0);
        chk({nm, " idle_busy"}, int'(m_busy), 0);
        if (c == len || c == last) chk_results(nm, exp_err, exp_fvec);
      end
    end
    chk({nm, " done_cycle"}, done_c, len);
    chk({nm, " done_count"}, done_n, 1);
  endtask

  typedef struct {
    int         sel;
    logic [1:0] op;
    logic [3:0] tt;
    bit         mid;
    int         err;
    int         fvec;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{sel: 0, op: 2'b00, tt: 4'b1000, mid: 0, err: 0, fvec: 0}; // AND ok
    tbl[1] = '{sel: 0, op: 2'b00, tt: 4'b0000, mid: 0, err: 1, fvec: 3}; // stuck 0
    tbl[2] = '{sel: 0, op: 2'b01, tt: 4'b1000, mid: 0, err: 2, fvec: 1}; // AND vs OR
    tbl[3] = '{sel: 0, op: 2'b00, tt: 4'b1000, mid: 1, err: 0, fvec: 0}; // starts ignored
    tbl[4] = '{sel: 1, op: 2'b10, tt: 4'b0110, mid: 0, err: 0, fvec: 0}; // XOR, settle 3
    tbl[5] = '{sel: 0, op: 2'b11, tt: 4'b0111, mid: 0, err: 0, fvec: 0}; // NAND ok
    tbl[6] = '{sel: 1, op: 2'b11, tt: 4'b1111, mid: 1, err: 1, fvec: 3}; // stuck 1
    tbl[7] = '{sel: 0, op: 2'b10, tt: 4'b0111, mid: 0, err: 1, fvec: 0}; // NAND vs XOR

    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; op = 2'b00;
    gate_tt = 4'b1000; cur_sel = 0;

    #2;
    chk("reset s1 outputs", int'({a1, b1, busy1, done1, pass1, err1, fv1, fvec1}), 0);
    chk("reset s3 outputs", int'({a3, b3, busy3, done3, pass3, err3, fv3, fvec3}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post reset s1 outputs", int'({a1, b1, busy1, done1, pass1, err1, fv1, fvec1}), 0);

    for (int i = 0; i < 8; i++)
      do_run(tbl[i].sel, tbl[i].op, tbl[i].tt, tbl[i].mid, 1'b0,
             tbl[i].err, tbl[i].fvec, $sformatf("tbl%0d", i));

    // Back-to-back: OR expected on an AND gate, then AND restarted in DONE.
    do_run(0, 2'b01, 4'b1000, 1'b0, 1'b1, 2, 1, "b2b_first");
    do_run(0, 2'b00, 4'b1000, 1'b0, 1'b0, 0, 0, "b2b_second");

    // Mid-run asynchronous reset in the v=2 DRIVE cycle (cycle 5 for settle 1).
    cur_sel = 0;
    gate_tt = 4'b0000;
    op      = 2'b11;
    start1  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    chk("pre-reset vec", int'({a1, b1}), 2);
    chk("pre-reset err_cnt", int'(err1), 2);
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", int'({a1, b1, busy1, done1, pass1, err1, fv1, fvec1}), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset held no done", int'({done1, busy1, a1, b1}), 0);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("after reset no done", int'({done1, busy1}), 0);
    end
    do_run(0, 2'b00, 4'b1000, 1'b0, 1'b0, 0, 0, "after_reset");

    // Randomised runs against the truth-table model.
    for (int i = 0; i < 20; i++) begin
      int         sel;
      logic [1:0] o;
      logic [3:0] tt;
      bit         mid;
      sel = int'($urandom_range(0, 1));
      o   = 2'($urandom_range(0, 3));
      tt  = 4'($urandom_range(0, 15));
      mid = 1'($urandom_range(0, 1));
      do_run(sel, o, tt, mid, 1'b0, model_err(o, tt), model_fvec(o, tt),
             $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
